// File: rtl/input_rom_feeder.sv
// Streams NUM_FRAMES passes over a synchronous ROM (addresses 0..LAST_ADDR) into a downstream FIFO write port.
// First byte appears 2 cycles after start; a 2-entry skid (output register + one spare) absorbs the ROM latency under full.
module input_rom_feeder #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int LAST_ADDR  = 4095,
  parameter int NUM_FRAMES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              full,
  output logic [DATA_W-1:0] data_in,
  output logic              in_en,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]        state;
  logic              rd_pend;   // a ROM read is in flight; its data is on rom_data this cycle
  logic              rd_last;   // that read is the last address of a frame
  logic              out_last;
  logic [DATA_W-1:0] sk_dat;
  logic              sk_vld;
  logic              sk_last;
  logic [7:0]        frm_iss;

  logic       xfer;
  logic       at_last;
  logic       final_addr;
  logic       issue;
  logic [1:0] occ_next;

  assign xfer       = in_en & ~full;
  // Occupancy once this cycle's transfer and in-flight read settle; a new read needs room for one more.
  assign occ_next   = {1'b0, in_en} + {1'b0, sk_vld} + {1'b0, rd_pend} - {1'b0, xfer};
  assign at_last    = (rom_addr == ADDR_W'(LAST_ADDR));
  assign final_addr = at_last && (frm_iss == 8'(NUM_FRAMES - 1));
  assign issue      = ((state == S_IDLE) && start) ||
                      (((state == S_PRIME) || (state == S_STREAM)) && (occ_next <= 2'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      data_in   <= '0;
      in_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
      out_last  <= 1'b0;
      sk_dat    <= '0;
      sk_vld    <= 1'b0;
      sk_last   <= 1'b0;
      frm_iss   <= 8'd0;
    end else begin
      done <= 1'b0;

      if (!in_en || xfer) begin
        if (sk_vld) begin
          data_in  <= sk_dat;
          out_last <= sk_last;
          in_en    <= 1'b1;
          sk_vld   <= rd_pend;
          sk_dat   <= rom_data;
          sk_last  <= rd_last;
        end else if (rd_pend) begin
          data_in  <= rom_data;
          out_last <= rd_last;
          in_en    <= 1'b1;
        end else begin
          in_en <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_dat  <= rom_data;
        sk_last <= rd_last;
        sk_vld  <= 1'b1;
      end

      if (xfer && out_last && (frame_cnt != 8'hFF))
        frame_cnt <= frame_cnt + 8'd1;

      rd_pend <= issue;
      if (issue) begin
        rd_last  <= at_last;
        rom_addr <= at_last ? '0 : rom_addr + ADDR_W'(1);
        if (at_last)
          frm_iss <= frm_iss + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= final_addr ? S_FLUSH : S_PRIME;
            busy      <= 1'b1;
            frame_cnt <= 8'd0;
          end
        end
        S_PRIME: begin
          state <= final_addr ? S_FLUSH : S_STREAM;
        end
        S_STREAM: begin
          if (issue && final_addr)
            state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (occ_next == 2'd0) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            frm_iss <= 8'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_rom_feeder.sv
// Scoreboard bench for input_rom_feeder: default-size instance plus a 2-frame x 16-byte instance.
module tb_input_rom_feeder;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          full = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] data_in;
  logic          in_en, busy, done;
  logic [7:0]    frame_cnt;

  logic          s_start = 1'b0;
  logic          s_full = 1'b0;
  logic [AW-1:0] s_rom_addr;
  logic [DW-1:0] s_rom_data;
  logic [DW-1:0] s_data_in;
  logic          s_in_en, s_busy, s_done;
  logic [7:0]    s_frame_cnt;

  input_rom_feeder #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(4095), .NUM_FRAMES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .full(full), .data_in(data_in), .in_en(in_en), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  input_rom_feeder #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(15), .NUM_FRAMES(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .full(s_full), .data_in(s_data_in), .in_en(s_in_en), .busy(s_busy), .done(s_done), .frame_cnt(s_frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs holding ROM[a] = a[7:0]
  always @(posedge clk) rom_data   <= rom_addr[7:0];
  always @(posedge clk) s_rom_data <= s_rom_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- main-instance monitor ----------------
  logic [DW-1:0] exp_q[$];
  int            xfer_cnt = 0;
  int            first_en_cyc = -1;
  int            done_cyc = -1;
  int            done_seen = 0;
  logic          prev_blk = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  always @(negedge clk) begin
    if (prev_blk) begin
      chk("hold_in_en", in_en, 1);
      chk("hold_data_in", data_in, prev_dat);
    end
    prev_blk = rst_n && in_en && full;
    prev_dat = data_in;
    if (in_en && first_en_cyc < 0) first_en_cyc = cyc;
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (rst_n && in_en && !full) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no transfer at cycle %0d", data_in, cyc);
      end else begin
        chk("byte_order", data_in, exp_q.pop_front());
      end
    end
  end

  // ---------------- small-instance monitor ----------------
  logic [DW-1:0] s_q[$];
  int            s_cnt = 0;
  int            s_done_cyc = -1;
  int            s_done_seen = 0;
  logic          s_mid_pend = 1'b0;

  always @(negedge clk) begin
    if (s_mid_pend) begin
      chk("s_frame_cnt_after_byte15", s_frame_cnt, 1);
      s_mid_pend = 1'b0;
    end
    if (s_done) begin
      s_done_seen++;
      s_done_cyc = cyc;
    end
    if (rst_n && s_in_en && !s_full) begin
      if (s_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_unexpected_byte: got 0x%0h, expected no transfer at cycle %0d", s_data_in, cyc);
      end else begin
        chk("s_byte_order", s_data_in, s_q.pop_front());
      end
      if (s_cnt == 15) s_mid_pend = 1'b1;
      s_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int a = 0; a < 4096; a++) exp_q.push_back(DW'(a));
  endtask

  task automatic pulse_start(output int c0);
    first_en_cyc = -1;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < limit && done_seen == d0; i++) tick();
    if (done_seen == d0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_xfer(input string name, input int target, input int limit);
    for (int i = 0; i < limit && xfer_cnt < target; i++) tick();
    if (xfer_cnt < target) chk({name, "_timeout"}, xfer_cnt, target);
  endtask

  initial begin
    int c0;
    int x0;
    int d0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_in_en", in_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_s_in_en", s_in_en, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Two frames of 16 bytes on the small instance
    for (int f = 0; f < 2; f++)
      for (int a = 0; a < 16; a++) s_q.push_back(DW'(a));
    s_start = 1'b1;
    c0 = cyc;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 200 && s_done_seen == 0; i++) tick();
    chk("s_done_seen", s_done_seen, 1);
    chk("s_done_latency", s_done_cyc - c0, 34);
    chk("s_frame_cnt_done", s_frame_cnt, 2);
    chk("s_bytes_left", s_q.size(), 0);
    chk("s_busy_after", s_busy, 0);

    // Free run, full never asserted
    chk("idle_rom_addr", rom_addr, 0);
    push_frame();
    pulse_start(c0);
    chk("prime_busy", busy, 1);
    chk("prime_in_en", in_en, 0);
    wait_done("free_done", 5000);
    chk("free_first_en", first_en_cyc - c0, 2);
    chk("free_done_cyc", done_cyc - c0, 4098);
    chk("free_done_pulse", done, 0);
    chk("free_busy_after", busy, 0);
    chk("free_frame_cnt", frame_cnt, 1);
    chk("free_bytes_left", exp_q.size(), 0);

    // Long stall on byte 9, then reset mid-run at byte 100
    push_frame();
    x0 = xfer_cnt;
    pulse_start(c0);
    wait_xfer("stall_reach9", x0 + 9, 100);
    chk("stall_byte9_shown", data_in, 9);
    full = 1'b1;
    repeat (20) tick();
    chk("stall_byte9_held", data_in, 9);
    chk("stall_count_frozen", xfer_cnt - x0, 9);
    full = 1'b0;
    wait_xfer("abort_reach100", x0 + 100, 200);
    chk("abort_byte100_shown", data_in, 100);
    d0 = done_seen;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_data_in", data_in, 0);
    chk("abort_in_en", in_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    repeat (10) tick();
    chk("abort_no_done", done_seen, d0);

    // Restart from 0 under random backpressure, with an ignored start mid-run
    push_frame();
    pulse_start(c0);
    d0 = done_seen;
    for (int i = 0; i < 20000 && done_seen == d0; i++) begin
      full  = 1'($urandom_range(0, 1));
      start = (i == 500);
      tick();
    end
    full  = 1'b0;
    start = 1'b0;
    chk("bp_done_seen", done_seen - d0, 1);
    chk("bp_frame_cnt", frame_cnt, 1);
    chk("bp_bytes_left", exp_q.size(), 0);
    repeat (10) tick();
    chk("bp_no_restart", in_en, 0);
    chk("bp_no_extra_done", done_seen - d0, 1);

    // Full held over the last byte for 3 cycles delays done by exactly 3
    push_frame();
    x0 = xfer_cnt;
    pulse_start(c0);
    wait_xfer("last_reach", x0 + 4095, 5000);
    chk("last_byte_shown", data_in, 8'hFF);
    full = 1'b1;
    repeat (3) tick();
    chk("last_no_done_yet", done_seen, d0 + 1);
    full = 1'b0;
    wait_done("last_done", 50);
    chk("last_done_cyc", done_cyc - c0, 4101);
    chk("last_frame_cnt", frame_cnt, 1);
    chk("last_bytes_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_rom_feeder.md
INPUT_ROM_FEEDER -- requirements
Module: input_rom_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, pixel byte width.
REQ-003 SHALL have parameter LAST_ADDR, default 4095, final ROM address of one frame.
REQ-004 SHALL have parameter NUM_FRAMES, default 1, frames streamed per start (1..255).
REQ-005 clk  input  1  single clock domain; all logic rising-edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins a run when idle.
REQ-008 rom_addr  output  ADDR_W  read address to synchronous ROM.
REQ-009 rom_data  input  DATA_W  ROM data, valid exactly 1 cycle after rom_addr is presented.
REQ-010 full  input  1  downstream FIFO write-full; transfer blocked while 1.
REQ-011 data_in  output  DATA_W  byte to downstream.
REQ-012 in_en  output  1  data_in valid.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the final byte transfers.
REQ-015 frame_cnt  output  8  frames fully transferred in current or last run.

Function
REQ-016 A transfer SHALL occur in any cycle where in_en=1 and full=0; no other cycle transfers.
REQ-017 While in_en=1 and full=1, data_in and in_en SHALL hold unchanged.
REQ-018 in_en SHALL be registered and SHALL never drop without a transfer, except on reset.
REQ-019 States SHALL be IDLE, PRIME, STREAM, FLUSH; PRIME lasts exactly one cycle (ROM latency fill).
REQ-020 IDLE->PRIME on start=1; rom_addr driven to 0 that cycle; busy asserts the next cycle.
REQ-021 start SHALL be ignored when not in IDLE.
REQ-022 PRIME->STREAM unconditionally; first in_en=1 appears on the cycle after PRIME, i.e. 2 cycles after start.
REQ-023 A 2-entry skid buffer SHALL absorb the ROM's 1-cycle latency, so that no byte is lost or duplicated when full toggles.
REQ-024 rom_addr SHALL advance only when the skid buffer has a free slot after this cycle's transfer.
REQ-025 With full=0 continuously, SHALL sustain one transfer per cycle.
REQ-026 Bytes SHALL be delivered in strictly ascending address order 0..LAST_ADDR, each exactly once per frame.
REQ-027 After LAST_ADDR is read, rom_addr SHALL wrap to 0 and frame_cnt SHALL increment on transfer of that frame's last byte.
REQ-028 After the last address of frame NUM_FRAMES is issued: STREAM->FLUSH, no further ROM reads.
REQ-029 FLUSH->IDLE when the skid buffer is empty; done=1 and busy=0 in the cycle following the final transfer.
REQ-030 frame_cnt SHALL clear on an accepted start and saturate at 255.
REQ-031 full asserting on the same cycle as the final byte SHALL delay done until that byte transfers.

Reset
REQ-032 On rst_n=0 at a clock edge: state=IDLE, rom_addr=0, data_in=0, in_en=0, busy=0, done=0, frame_cnt=0, skid buffer emptied.
REQ-033 Reset mid-run SHALL abandon the run without a done pulse; the next start restarts from address 0.

Verification
REQ-034 Free run: ROM[a]=a[7:0], full=0, start at cycle 0 -> in_en=1 from cycle 2, 4096 consecutive bytes 0x00..0xFF repeating, done at cycle 4098, frame_cnt=1.
REQ-035 Backpressure: full toggled pseudo-randomly ~50% -> received sequence identical to REQ-034, no gaps in address order, data_in stable while blocked.
REQ-036 full held 1 for 20 cycles starting at the 10th byte -> byte 9 held on data_in throughout; next transfers are 9, 10, 11.
REQ-037 NUM_FRAMES=2, LAST_ADDR=15 -> 32 bytes 0..15,0..15, frame_cnt 1 after byte 15, 2 at done.
REQ-038 start re-pulsed mid-run -> ignored, byte count unchanged; rst_n=0 at byte 100 -> all outputs 0 next cycle, no done, restart from 0.
REQ-039 full=1 on the last-byte cycle for 3 cycles -> done delayed exactly 3 cycles.
